qos_vc_buffer_arb: RTL and testbench

// Parametrised QoS ingress stage. Demuxes one input stream by its VC-id field into NUM_VC per-VC FIFOs,

---
 rtl/qos_vc_buffer_arb.sv | 161 ++++++++++++++++
 tb/tb_qos_vc_buffer_arb.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qos_vc_buffer_arb.sv
// QoS ingress stage: demuxes one stream into per-VC FIFOs, raises hysteresis pause flags,
// arbitrates the VCs (round robin or strict priority) onto one valid/ready output register.
module qos_vc_buffer_arb #(
  parameter int  BW     = 6,
  parameter int  NUM_VC = 4,
  parameter int  DEPTH  = 16,
  localparam int VCW    = $clog2(NUM_VC),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 init,
  input  logic [NUM_VC*CW-1:0] thr_high,
  input  logic [NUM_VC*CW-1:0] thr_low,
  input  logic                 arb_mode,
  input  logic                 in_wr,
  input  logic [BW-1:0]        in_data,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [BW-1:0]        out_data,
  output logic [NUM_VC-1:0]    pause,
  output logic [NUM_VC-1:0]    fifo_empty,
  output logic [NUM_VC-1:0]    error_full,
  output logic                 idle_out,
  output logic                 active_out,
  output logic                 error_out
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_RESET,
    ST_INIT,
    ST_IDLE,
    ST_ACTIVE,
    ST_ERROR
  } state_t;

  state_t state, state_nxt;

  logic [BW-1:0]                 mem [NUM_VC][DEPTH];
  logic [NUM_VC-1:0][AW-1:0]     wr_ptr, rd_ptr;
  logic [NUM_VC-1:0][CW-1:0]     cnt, cnt_nxt;
  logic [NUM_VC-1:0][CW-1:0]     thr_hi_q, thr_lo_q;
  logic [VCW-1:0]                rr_ptr, win, rr_idx, wr_vc;
  logic [NUM_VC-1:0]             nonempty, wr_en, drop, pop;
  logic                          accept, load, found;

  assign wr_vc      = in_data[BW-1 -: VCW];
  assign accept     = (state != ST_RESET) && (state != ST_INIT);
  assign fifo_empty = ~nonempty;

  // Write steering; fullness is judged on the registered count, so a same-cycle pop never frees room.
  always_comb begin
    // NOTE: every variable assigned in an always_comb gets a default first so no path infers a latch.
    nonempty = '0;
    wr_en    = '0;
    drop     = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      nonempty[v] = (cnt[v] != '0);
      if (in_wr && accept && (wr_vc == VCW'(v))) begin
        if (cnt[v] == CW'(DEPTH)) drop[v]  = 1'b1;
        else                      wr_en[v] = 1'b1;
      end
    end
  end

  always_comb begin
    win    = '0;
    found  = 1'b0;
    rr_idx = '0;
    if (arb_mode) begin
      for (int v = 0; v < NUM_VC; v++)
        if (nonempty[v]) win = VCW'(v);
    end else begin
      // Search starts just after the last winner; VCW-bit addition wraps NUM_VC-1 -> 0.
      for (int i = 1; i <= NUM_VC; i++) begin
        rr_idx = rr_ptr + VCW'(i);
        if (!found && nonempty[rr_idx]) begin
          win   = rr_idx;
          found = 1'b1;
        end
      end
    end
    load = (!out_valid || out_ready) && (|nonempty);
    pop  = '0;
    if (load) pop[win] = 1'b1;
  end

  always_comb begin
    for (int v = 0; v < NUM_VC; v++)
      cnt_nxt[v] = cnt[v] + CW'(wr_en[v]) - CW'(pop[v]);
  end

  always_comb begin
    state_nxt = state;
    if (init)       state_nxt = ST_INIT;
    else if (|drop) state_nxt = ST_ERROR;
    else begin
      unique case (state)
        ST_RESET:            state_nxt = ST_RESET;
        ST_INIT:             state_nxt = ST_IDLE;
        ST_IDLE, ST_ACTIVE:  state_nxt = ((|nonempty) || out_valid) ? ST_ACTIVE : ST_IDLE;
        ST_ERROR:            state_nxt = ST_ERROR;
        default:             state_nxt = ST_RESET;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state      <= ST_RESET;
      idle_out   <= 1'b0;
      active_out <= 1'b0;
      error_out  <= 1'b0;
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      thr_hi_q   <= '0;
      thr_lo_q   <= '0;
      pause      <= '0;
      error_full <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      rr_ptr     <= VCW'(NUM_VC - 1);
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      state      <= state_nxt;
      idle_out   <= (state_nxt == ST_IDLE);
      active_out <= (state_nxt == ST_ACTIVE);
      error_out  <= (state_nxt == ST_ERROR);
      for (int v = 0; v < NUM_VC; v++) begin
        cnt[v] <= cnt_nxt[v];
        if (wr_en[v]) wr_ptr[v] <= wr_ptr[v] + AW'(1);
        if (pop[v])   rd_ptr[v] <= rd_ptr[v] + AW'(1);
        // Set has priority, so thr_low >= thr_high degenerates to a plain threshold.
        if (cnt_nxt[v] >= thr_hi_q[v])      pause[v] <= 1'b1;
        else if (cnt_nxt[v] <= thr_lo_q[v]) pause[v] <= 1'b0;
        if (state == ST_INIT) begin
          thr_hi_q[v] <= thr_high[v*CW +: CW];
          thr_lo_q[v] <= thr_low[v*CW +: CW];
        end
      end
      if (state == ST_INIT) error_full <= '0;
      else                  error_full <= error_full | drop;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= mem[win][rd_ptr[win]];
        rr_ptr    <= win;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; the occupancy counters alone decide which entries are live.
    for (int v = 0; v < NUM_VC; v++)
      if (wr_en[v]) mem[v][wr_ptr[v]] <= in_data;
  end

endmodule

// File: tb/tb_qos_vc_buffer_arb.sv
// Self-checking bench for qos_vc_buffer_arb: directed scenarios plus randomized traffic checked
// against a queue-based behavioural model of the VC buffer, arbiter and control FSM.
module tb_qos_vc_buffer_arb;
  localparam int BW     = 6;
  localparam int NUM_VC = 4;
  localparam int DEPTH  = 16;
  localparam int VCW    = $clog2(NUM_VC);
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int VW     = 1 + BW + 3*NUM_VC + 3;

  logic                 clk;
  logic                 reset_L;
  logic                 init;
  logic [NUM_VC*CW-1:0] thr_high;
  logic [NUM_VC*CW-1:0] thr_low;
  logic                 arb_mode;
  logic                 in_wr;
  logic [BW-1:0]        in_data;
  logic                 out_ready;
  logic                 out_valid;
  logic [BW-1:0]        out_data;
  logic [NUM_VC-1:0]    pause;
  logic [NUM_VC-1:0]    fifo_empty;
  logic [NUM_VC-1:0]    error_full;
  logic                 idle_out;
  logic                 active_out;
  logic                 error_out;

  qos_vc_buffer_arb #(.BW(BW), .NUM_VC(NUM_VC), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .init       (init),
    .thr_high   (thr_high),
    .thr_low    (thr_low),
    .arb_mode   (arb_mode),
    .in_wr      (in_wr),
    .in_data    (in_data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .pause      (pause),
    .fifo_empty (fifo_empty),
    .error_full (error_full),
    .idle_out   (idle_out),
    .active_out (active_out),
    .error_out  (error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  int errors = 0;
  int checks = 0;

  // Behavioural model: one queue per VC, an output slot and the control-state label.
  typedef enum {MS_RESET, MS_INIT, MS_IDLE, MS_ACTIVE, MS_ERROR} mstate_t;
  mstate_t           m_state;
  logic [BW-1:0]     q [NUM_VC][$];
  bit                m_ov;
  logic [BW-1:0]     m_od;
  int                m_last;
  int                m_hi [NUM_VC];
  int                m_lo [NUM_VC];
  bit [NUM_VC-1:0]   m_pause;
  bit [NUM_VC-1:0]   m_err;

  task automatic model_reset();
    for (int v = 0; v < NUM_VC; v++) begin
      q[v].delete();
      m_hi[v] = 0;
      m_lo[v] = 0;
    end
    m_state = MS_RESET;
    m_ov    = 0;
    m_od    = '0;
    m_last  = NUM_VC - 1;
    m_pause = '0;
    m_err   = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven, then clock the DUT.
  task automatic tick();
    bit            accept, drop, push, any, load;
    int            wv, win, n;
    mstate_t       nxt;
    accept = (m_state != MS_RESET) && (m_state != MS_INIT);
    wv     = int'(in_data[BW-1 -: VCW]);
    drop   = 0;
    push   = 0;
    if (in_wr && accept) begin
      if (q[wv].size() == DEPTH) drop = 1;
      else                       push = 1;
    end
    any = 0;
    for (int v = 0; v < NUM_VC; v++) if (q[v].size() != 0) any = 1;
    load = (!m_ov || out_ready) && any;
    win  = -1;
    if (load) begin
      if (arb_mode) begin
        for (int v = NUM_VC - 1; v >= 0; v--)
          if (win < 0 && q[v].size() != 0) win = v;
      end else begin
        for (int k = 1; k <= NUM_VC; k++)
          if (win < 0 && q[(m_last + k) % NUM_VC].size() != 0) win = (m_last + k) % NUM_VC;
      end
    end
    if (init)      nxt = MS_INIT;
    else if (drop) nxt = MS_ERROR;
    else if (m_state == MS_INIT) nxt = MS_IDLE;
    else if (m_state == MS_IDLE || m_state == MS_ACTIVE) nxt = (any || m_ov) ? MS_ACTIVE : MS_IDLE;
    else nxt = m_state;
    if (load) begin
      m_od   = q[win].pop_front();
      m_ov   = 1;
      m_last = win;
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (push) q[wv].push_back(in_data);
    for (int v = 0; v < NUM_VC; v++) begin
      n = q[v].size();
      if (n >= m_hi[v])      m_pause[v] = 1;
      else if (n <= m_lo[v]) m_pause[v] = 0;
    end
    if (m_state == MS_INIT) begin
      for (int v = 0; v < NUM_VC; v++) begin
        m_hi[v] = int'(thr_high[v*CW +: CW]);
        m_lo[v] = int'(thr_low[v*CW +: CW]);
      end
      m_err = '0;
    end else if (drop) begin
      m_err[wv] = 1;
    end
    m_state = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic set_thr(input int hi, input int lo);
    for (int v = 0; v < NUM_VC; v++) begin
      thr_high[v*CW +: CW] = CW'(hi);
      thr_low[v*CW +: CW]  = CW'(lo);
    end
  endtask

  task automatic do_init();
    init = 1;
    tick();
    init = 0;
    tick();
  endtask

  task automatic test_reset();
    #1 reset_L = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
    checks++; if (pause !== '0) begin errors++; $display("FAIL reset_pause: got %0h want 0", pause); end
    checks++; if (error_full !== '0) begin errors++; $display("FAIL reset_error_full: got %0h want 0", error_full); end
    checks++; if (fifo_empty !== 4'hF) begin errors++; $display("FAIL reset_fifo_empty: got %0h want f", fifo_empty); end
    checks++; if ({idle_out, active_out, error_out} !== 3'b000) begin errors++; $display("FAIL reset_status: got %0b want 000", {idle_out, active_out, error_out}); end
    #1 reset_L = 1;
    in_wr   = 1;
    in_data = 6'h15;
    repeat (3) tick();
    in_wr = 0;
    checks++; if (fifo_empty !== 4'hF) begin errors++; $display("FAIL preinit_write_ignored: fifo_empty got %0h want f", fifo_empty); end
    checks++; if (error_full !== '0 || error_out !== 1'b0) begin errors++; $display("FAIL preinit_no_error: got %0h/%0b want 0/0", error_full, error_out); end
    checks++; if ({idle_out, active_out, error_out} !== 3'b000) begin errors++; $display("FAIL preinit_status: got %0b want 000", {idle_out, active_out, error_out}); end
    checks++; if (pause !== m_pause) begin errors++; $display("FAIL preinit_pause: got %0h want %0h", pause, m_pause); end
  endtask

  task automatic test_single();
    set_thr(12, 4);
    out_ready = 1;
    do_init();
    in_wr   = 1;
    in_data = 6'b01_0101;
    tick();
    in_wr = 0;
    checks++; if (out_valid !== 1'b0 || idle_out !== 1'b1) begin errors++; $display("FAIL single_edge1: valid/idle got %0b/%0b want 0/1", out_valid, idle_out); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 6'h15) begin errors++; $display("FAIL single_latency: valid/data got %0b/%0h want 1/15", out_valid, out_data); end
    checks++; if (active_out !== 1'b1) begin errors++; $display("FAIL single_active: got %0b want 1", active_out); end
    tick();
    checks++; if (out_valid !== 1'b0 || active_out !== 1'b1) begin errors++; $display("FAIL single_drain: valid/active got %0b/%0b want 0/1", out_valid, active_out); end
    tick();
    checks++; if (idle_out !== 1'b1 || fifo_empty !== 4'hF) begin errors++; $display("FAIL single_idle: idle/empty got %0b/%0h want 1/f", idle_out, fifo_empty); end
    checks++; if (pause !== 4'h0) begin errors++; $display("FAIL single_pause: got %0h want 0", pause); end
  endtask

  task automatic test_pause();
    out_ready = 0;
    in_wr     = 1;
    for (int i = 0; i < 13; i++) begin
      in_data = {2'b10, 4'(i)};
      tick();
      checks++; if (pause[2] !== m_pause[2]) begin errors++; $display("FAIL pause_fill[%0d]: got %0b want %0b", i, pause[2], m_pause[2]); end
    end
    in_wr = 0;
    checks++; if (pause !== 4'b0100) begin errors++; $display("FAIL pause_set: got %0h want 4", pause); end
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++; if (pause[2] !== m_pause[2] || out_valid !== m_ov || out_data !== m_od) begin
        errors++; $display("FAIL pause_drain[%0d]: pause/valid/data got %0b/%0b/%0h want %0b/%0b/%0h",
                           i, pause[2], out_valid, out_data, m_pause[2], m_ov, m_od);
      end
    end
    checks++; if (pause !== 4'b0000) begin errors++; $display("FAIL pause_clear: got %0h want 0", pause); end
  endtask

  task automatic test_overflow();
    out_ready = 0;
    in_wr     = 1;
    for (int i = 0; i < 18; i++) begin
      in_data = {2'b00, 4'(i)};
      tick();
      if (i == 16) begin
        checks++; if (error_full !== 4'b0000) begin errors++; $display("FAIL ovf_not_yet: got %0h want 0", error_full); end
      end
    end
    in_wr = 0;
    checks++; if (error_full !== 4'b0001) begin errors++; $display("FAIL ovf_error_full: got %0h want 1", error_full); end
    checks++; if (error_out !== 1'b1) begin errors++; $display("FAIL ovf_error_out: got %0b want 1", error_out); end
    do_init();
    checks++; if (error_full !== 4'b0000 || error_out !== 1'b0) begin errors++; $display("FAIL ovf_init_clear: got %0h/%0b want 0/0", error_full, error_out); end
    checks++; if ((idle_out | active_out) !== 1'b1) begin errors++; $display("FAIL ovf_init_state: idle/active got %0b/%0b", idle_out, active_out); end
    out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (out_valid !== m_ov || (m_ov && out_data !== m_od)) begin
        errors++; $display("FAIL ovf_drain[%0d]: valid/data got %0b/%0h want %0b/%0h", i, out_valid, out_data, m_ov, m_od);
      end
    end
  endtask

  task automatic test_arbitration();
    int got[$];
    int ord_rr[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int ord_sp[8] = '{3, 2, 1, 0, 3, 2, 1, 0};
    int exp_rr[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_sp[8] = '{3, 3, 2, 2, 1, 1, 0, 0};
    int vc, ev, gv;
    for (int pass = 0; pass < 2; pass++) begin
      arb_mode  = (pass == 1);
      out_ready = 0;
      in_wr     = 1;
      for (int i = 0; i < 8; i++) begin
        vc      = (pass == 1) ? ord_sp[i] : ord_rr[i];
        in_data = {VCW'(vc), 4'(i)};
        tick();
      end
      in_wr     = 0;
      out_ready = 1;
      got.delete();
      for (int t = 0; t < 12; t++) begin
        if (out_valid) got.push_back(int'(out_data[BW-1 -: VCW]));
        tick();
      end
      checks++; if (got.size() != 8) begin errors++; $display("FAIL arb_count mode=%0d: got %0d words want 8", pass, got.size()); end
      for (int i = 0; i < 8; i++) begin
        ev = (pass == 1) ? exp_sp[i] : exp_rr[i];
        gv = (i < got.size()) ? got[i] : -1;
        checks++; if (gv != ev) begin errors++; $display("FAIL arb_order mode=%0d idx=%0d: got vc %0d want vc %0d", pass, i, gv, ev); end
      end
    end
    arb_mode = 0;
  endtask

  task automatic test_random();
    logic [VW-1:0]     got_v, exp_v;
    logic [NUM_VC-1:0] m_empty;
    bit                prev_valid, prev_ready;
    logic [BW-1:0]     prev_data;
    int                hi;
    for (int v = 0; v < NUM_VC; v++) begin
      hi = $urandom_range(4, 15);
      thr_high[v*CW +: CW] = CW'(hi);
      thr_low[v*CW +: CW]  = (v == NUM_VC - 1) ? CW'(hi) : CW'($urandom_range(0, hi - 1));
    end
    do_init();
    for (int c = 0; c < 500; c++) begin
      in_wr     = ($urandom_range(0, 99) < 55);
      in_data   = BW'($urandom);
      out_ready = ($urandom_range(0, 99) < 50);
      init      = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 5) arb_mode = ~arb_mode;
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      tick();
      for (int v = 0; v < NUM_VC; v++) m_empty[v] = (q[v].size() == 0);
      exp_v = {m_ov, m_od, m_pause, m_empty, m_err,
               m_state == MS_IDLE, m_state == MS_ACTIVE, m_state == MS_ERROR};
      got_v = {out_valid, out_data, pause, fifo_empty, error_full, idle_out, active_out, error_out};
      checks++; if (got_v !== exp_v) begin errors++; $display("FAIL random_cycle[%0d]: outputs got %0h want %0h", c, got_v, exp_v); end
      if (prev_valid && !prev_ready) begin
        checks++; if (out_valid !== 1'b1 || out_data !== prev_data) begin
          errors++; $display("FAIL stall_stable[%0d]: valid/data got %0b/%0h want 1/%0h", c, out_valid, out_data, prev_data);
        end
      end
    end
    init  = 0;
    in_wr = 0;
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    in_wr     = 1;
    for (int i = 0; i < 6; i++) begin
      in_data = BW'($urandom);
      tick();
    end
    in_wr = 0;
    #2 reset_L = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL midreset_output: valid/data got %0b/%0h want 0/0", out_valid, out_data); end
    checks++; if (pause !== '0 || error_full !== '0) begin errors++; $display("FAIL midreset_flags: pause/err got %0h/%0h want 0/0", pause, error_full); end
    checks++; if (fifo_empty !== 4'hF) begin errors++; $display("FAIL midreset_empty: got %0h want f", fifo_empty); end
    checks++; if ({idle_out, active_out, error_out} !== 3'b000) begin errors++; $display("FAIL midreset_status: got %0b want 000", {idle_out, active_out, error_out}); end
    model_reset();
    #1 reset_L = 1;
    in_wr = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = BW'($urandom);
      tick();
    end
    in_wr = 0;
    checks++; if (fifo_empty !== 4'hF || out_valid !== 1'b0) begin errors++; $display("FAIL postreset_ignored: empty/valid got %0h/%0b want f/0", fifo_empty, out_valid); end
    checks++; if (error_full !== '0 || error_out !== 1'b0) begin errors++; $display("FAIL postreset_no_error: got %0h/%0b want 0/0", error_full, error_out); end
    checks++; if (pause !== m_pause) begin errors++; $display("FAIL postreset_pause: got %0h want %0h", pause, m_pause); end
  endtask

  initial begin
    reset_L   = 1;
    init      = 0;
    thr_high  = '0;
    thr_low   = '0;
    arb_mode  = 0;
    in_wr     = 0;
    in_data   = '0;
    out_ready = 0;
    model_reset();
    test_reset();
    test_single();
    test_pause();
    test_overflow();
    test_arbitration();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
